pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates the per-stage reg_lock signals and the bubble/flush controls.
- Detects load-use hazards, sequences the multi-cycle multiplier in EX, and honours data-memory wait requests.
- Replaces the constant-zero lock registers in the top-level datapath; all stage lock inputs connect here.

---
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle multiply, dmem wait.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_regA,
   input  logic [4:0]       id_regB,
   input  logic             id_uses_A,
   input  logic             id_uses_B,
   input  logic             id_is_mult,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_write_reg,
   input  logic             jump_or_branch_id,
   input  logic             dmem_wait,
   output logic             lock_if,
   output logic             lock_id,
   output logic             lock_ex,
   output logic             lock_mem,
   output logic             lock_wb,
   output logic             bubble_ex,
   output logic             bubble_mem,
   output logic             bubble_wb,
   output logic             flush_if,
   output logic             mult_busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned MCNT_W = 4;

   typedef enum logic [1:0] {RUN, MULT, MEMW} state_t;

   state_t            state, state_nxt;
   logic [MCNT_W-1:0] mcnt, mcnt_nxt;
   logic              hazard;

   // Register 0 is hardwired zero, so a load targeting it never creates a dependency
   assign hazard = ex_mem_read && (ex_write_reg != 5'd0) &&
                   ((id_uses_A && (id_regA == ex_write_reg)) ||
                    (id_uses_B && (id_regB == ex_write_reg)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         mcnt  <= '0;
      end else begin
         state <= state_nxt;
         mcnt  <= mcnt_nxt;
      end
   end

   // Next state and pipeline controls; dmem_wait overrides everything
   always_comb begin
      state_nxt  = state;
      mcnt_nxt   = mcnt;
      lock_if    = 1'b0;
      lock_id    = 1'b0;
      lock_ex    = 1'b0;
      lock_mem   = 1'b0;
      lock_wb    = 1'b0;
      bubble_ex  = 1'b0;
      bubble_mem = 1'b0;
      bubble_wb  = 1'b0;
      flush_if   = 1'b0;
      mult_busy  = (state == MULT);

      if (dmem_wait) begin
         lock_if   = 1'b1;
         lock_id   = 1'b1;
         lock_ex   = 1'b1;
         lock_mem  = 1'b1;
         bubble_wb = 1'b1;
         if (state != MULT) state_nxt = MEMW;
      end else if (state == MULT) begin
         lock_if    = 1'b1;
         lock_id    = 1'b1;
         lock_ex    = 1'b1;
         bubble_mem = 1'b1;
         if (mcnt <= MCNT_W'(1)) begin
            state_nxt = RUN;
            mcnt_nxt  = '0;
         end else begin
            mcnt_nxt = mcnt - MCNT_W'(1);
         end
      end else begin
         state_nxt = RUN;
         if (hazard) begin
            lock_if   = 1'b1;
            lock_id   = 1'b1;
            bubble_ex = 1'b1;
         end else if (id_is_mult) begin
            state_nxt = MULT;
            mcnt_nxt  = MCNT_W'(MULT_CYCLES - 1);
         end
      end

      // A branch only redirects once it actually leaves ID
      if (jump_or_branch_id && !lock_id) flush_if = 1'b1;
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (lock_if && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (flush_if && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MULT_CYCLES=4).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W = 16;

   // {lock_if,lock_id,lock_ex,lock_mem,lock_wb,bubble_ex,bubble_mem,bubble_wb,flush_if,mult_busy}
   localparam logic [9:0] IDLE = 10'b00000_00000;
   localparam logic [9:0] LU   = 10'b11000_10000;
   localparam logic [9:0] MUL  = 10'b11100_01001;
   localparam logic [9:0] DW   = 10'b11110_00100;
   localparam logic [9:0] DWM  = 10'b11110_00101;
   localparam logic [9:0] FL   = 10'b00000_00010;

   typedef struct {
      string      tag;
      logic [9:0] exp;
   } sb_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       id_regA, id_regB, ex_write_reg;
   logic             id_uses_A, id_uses_B, id_is_mult, ex_mem_read;
   logic             jump_or_branch_id, dmem_wait;
   logic             lock_if, lock_id, lock_ex, lock_mem, lock_wb;
   logic             bubble_ex, bubble_mem, bubble_wb, flush_if, mult_busy;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   sb_t sb_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   pipeline_hazard_ctrl #(.MULT_CYCLES(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_regA(id_regA), .id_regB(id_regB),
      .id_uses_A(id_uses_A), .id_uses_B(id_uses_B),
      .id_is_mult(id_is_mult), .ex_mem_read(ex_mem_read),
      .ex_write_reg(ex_write_reg), .jump_or_branch_id(jump_or_branch_id),
      .dmem_wait(dmem_wait),
      .lock_if(lock_if), .lock_id(lock_id), .lock_ex(lock_ex),
      .lock_mem(lock_mem), .lock_wb(lock_wb),
      .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
      .flush_if(flush_if), .mult_busy(mult_busy),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, push its expectation, compare at the falling edge
   task automatic step(input string tag, input logic rn,
                       input logic [4:0] ra, input logic ua,
                       input logic [4:0] rb, input logic ub,
                       input logic mult, input logic mr, input logic [4:0] wr,
                       input logic br, input logic dw, input logic [9:0] exp);
      sb_t e;
      @(posedge clk);
      #1;
      rst_n = rn; id_regA = ra; id_uses_A = ua; id_regB = rb; id_uses_B = ub;
      id_is_mult = mult; ex_mem_read = mr; ex_write_reg = wr;
      jump_or_branch_id = br; dmem_wait = dw;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, 32'({lock_if, lock_id, lock_ex, lock_mem, lock_wb, bubble_ex,
                           bubble_mem, bubble_wb, flush_if, mult_busy}), 32'(e.exp));
      end
   endtask

   task automatic idle(input string tag, input logic [9:0] exp);
      step(tag, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
   endtask

   task automatic check_perf(input string tag, input int st, input int fl);
`ifdef HAZARD_PERF_EN
      check({tag, "_stall"}, 32'(stall_cycles), 32'(st));
      check({tag, "_flush"}, 32'(flush_count), 32'(fl));
`else
      check({tag, "_stall"}, 32'(stall_cycles), 32'd0);
      check({tag, "_flush"}, 32'(flush_count), 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; id_regA = '0; id_regB = '0; ex_write_reg = '0;
      id_uses_A = 1'b0; id_uses_B = 1'b0; id_is_mult = 1'b0; ex_mem_read = 1'b0;
      jump_or_branch_id = 1'b0; dmem_wait = 1'b0;
      repeat (2) @(posedge clk);

      idle("reset_idle", IDLE);
      check_perf("perf_reset", 0, 0);

      // 1 load-use stall + 3 multiply cycles + 1 flush
      step("lu_r5", 1, 5'd5, 1, 5'd0, 0, 0, 1, 5'd5, 0, 0, LU);
      idle("lu_after", IDLE);
      step("mul_issue", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0, IDLE);
      idle("mul_c1", MUL);
      idle("mul_c2", MUL);
      idle("mul_c3", MUL);
      idle("mul_done", IDLE);
      step("br_plain", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 0, FL);
      idle("perf_idle", IDLE);
      check_perf("perf_mix", 4, 1);

      step("lu_r0", 1, 5'd0, 1, 5'd0, 0, 0, 1, 5'd0, 0, 0, IDLE);
      step("lu_regB", 1, 5'd0, 0, 5'd7, 1, 0, 1, 5'd7, 0, 0, LU);
      idle("lu_regB_after", IDLE);
      step("lu_unused_A", 1, 5'd5, 0, 5'd3, 1, 0, 1, 5'd5, 0, 0, IDLE);
      step("lu_no_load", 1, 5'd5, 1, 5'd0, 0, 0, 0, 5'd5, 0, 0, IDLE);

      // dmem_wait while counter is 2 freezes it
      step("mw_issue", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0, IDLE);
      idle("mw_c3", MUL);
      step("mw_dw1", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, DWM);
      step("mw_dw2", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, DWM);
      step("mw_dw3", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, DWM);
      idle("mw_c2", MUL);
      idle("mw_c1", MUL);
      idle("mw_done", IDLE);

      step("br_lu_stall", 1, 5'd9, 1, 5'd0, 0, 0, 1, 5'd9, 1, 0, LU);
      step("br_lu_flush", 1, 5'd9, 1, 5'd0, 0, 0, 0, 5'd0, 1, 0, FL);

      // back-to-back multiply held in ID during MULT
      step("b2b_issue1", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0, IDLE);
      step("b2b_hold1", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 1, 0, MUL);
      step("b2b_hold2", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0, MUL);
      step("b2b_lu_in_mult", 1, 5'd4, 1, 5'd0, 0, 0, 1, 5'd4, 0, 0, MUL);
      step("b2b_lu_rerun", 1, 5'd4, 1, 5'd0, 0, 1, 1, 5'd4, 0, 0, LU);
      step("b2b_issue2", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0, IDLE);
      idle("b2b_c1", MUL);
      idle("b2b_c2", MUL);
      idle("b2b_c3", MUL);
      idle("b2b_done", IDLE);

      // MEMW entry, hold, and release into normal RUN evaluation
      step("memw_br", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 1, DW);
      step("memw_hold", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 1, 1, DW);
      step("memw_rel_lu", 1, 5'd0, 0, 5'd6, 1, 1, 1, 5'd6, 1, 0, LU);
      step("memw_br_go", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 0, FL);

      // synchronous reset in the middle of a multiply
      step("rst_issue", 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0, IDLE);
      idle("rst_c1", MUL);
      step("rst_assert", 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, MUL);
      idle("rst_run", IDLE);
      idle("rst_run2", IDLE);
      check_perf("perf_after_rst", 0, 0);

      // synchronous reset during a memory wait
      step("rst_memw", 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, DW);
      step("rst_memw_assert", 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, DW);
      idle("rst_memw_run", IDLE);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
